// File: rtl/serial_comparator_pkg.sv
// Shared definitions for the LSB-first serial magnitude comparator.
// State encodings are exported so the bench can reuse them.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/lsb_slice_update.sv
// One 2-bit slice step of the LSB-first compare; purely combinational.
// A differing slice overrides whatever the less significant slices decided.
module lsb_slice_update (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       eq_in,
  input  logic       lt_in,
  output logic       eq_out,
  output logic       lt_out
);

  always_comb begin
    eq_out = eq_in;
    lt_out = lt_in;
    if (a != b) begin
      eq_out = 1'b0;
      lt_out = (a < b);
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Sequential unsigned comparator walking A/B LSB-first, one 2-bit slice per clock.
// Latency SIZE/2 edges from acceptance to done; start is ignored while busy.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic            busy,
  output logic            done,
  output logic            EQ,
  output logic            LT
);

  localparam int NSLICE = SIZE / 2;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            eqw_q, eqw_d, ltw_q, ltw_d;
  logic            eq_q, eq_d, lt_q, lt_d;
  logic            slice_eq, slice_lt;

  lsb_slice_update u_slice (
    .a      (sa_q[SLICE_W-1:0]),
    .b      (sb_q[SLICE_W-1:0]),
    .eq_in  (eqw_q),
    .lt_in  (ltw_q),
    .eq_out (slice_eq),
    .lt_out (slice_lt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      eqw_q   <= 1'b0;
      ltw_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      eqw_q   <= eqw_d;
      ltw_q   <= ltw_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    eqw_d   = eqw_q;
    ltw_d   = ltw_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          eqw_d   = 1'b1;
          ltw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        eqw_d = slice_eq;
        ltw_d = slice_lt;
        sa_d  = sa_q >> SLICE_W;
        sb_d  = sb_q >> SLICE_W;
        if (cnt_q == CNT_LAST) begin
          // Results are taken from the final slice step directly so they land on the DONE edge.
          eq_d    = slice_eq;
          lt_d    = slice_lt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign EQ   = eq_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator at SIZE=8 and SIZE=2.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy8, done8, eq8, lt8;
  logic       busy2, done2, eq2, lt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_comparator #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .EQ(eq8), .LT(lt8)
  );

  serial_comparator #(.SIZE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .EQ(eq2), .LT(lt2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       eq;
    logic       lt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp8(input logic [7:0] a, input logic [7:0] b, input logic e_eq, input logic e_lt,
                      input string name);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    chk({name, " busy_after_accept"}, int'(busy8), 1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    chk({name, " latency"}, lat, 4);
    chk({name, " EQ"}, int'(eq8), int'(e_eq));
    chk({name, " LT"}, int'(lt8), int'(e_lt));
    @(posedge clk);
    #1;
    chk({name, " busy_fall"}, int'(busy8), 0);
    chk({name, " done_single"}, int'(done8), 0);
  endtask

  task automatic cmp2(input logic [1:0] a, input logic [1:0] b, input logic e_eq, input logic e_lt,
                      input string name);
    int lat;
    @(negedge clk);
    a2 = a; b2 = b; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    a2 = ~a; b2 = ~b;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, lat, 1);
    chk({name, " EQ"}, int'(eq2), int'(e_eq));
    chk({name, " LT"}, int'(lt2), int'(e_lt));
    @(posedge clk);
    #1;
    chk({name, " busy_fall"}, int'(busy2), 0);
  endtask

  initial begin
    int ndone, first_i, last_i, prev_done, seen;

    vecs[0] = '{8'h5A, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{8'h13, 8'h21, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{8'h12, 8'h13, 1'b0, 1'b1};
    vecs[8] = '{8'h31, 8'h13, 1'b0, 1'b0};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy8), 0);
    chk("reset done", int'(done8), 0);
    chk("reset EQ", int'(eq8), 0);
    chk("reset LT", int'(lt8), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cmp8(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].lt, $sformatf("vec%0d", i));
    end

    // start held high with operands toggling every cycle; acceptances are 6 edges apart, so each captures the same phase.
    ndone = 0; first_i = -1; last_i = -1; prev_done = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start8 = 1'b1;
      if (i % 2 == 0) begin a8 = 8'h13; b8 = 8'h21; end
      else            begin a8 = 8'h21; b8 = 8'h13; end
      @(posedge clk);
      #1;
      if (done8) begin
        if (prev_done != 0) chk("held no_consecutive_done", 1, 0);
        if (ndone == 0) first_i = i;
        else chk("held done_interval", i - last_i, 6);
        last_i = i;
        ndone++;
        chk("held EQ", int'(eq8), 0);
        chk("held LT", int'(lt8), 1);
      end
      prev_done = int'(done8);
    end
    chk("held first_done", first_i, 4);
    chk("held done_count", ndone, 3);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held drained", int'(busy8), 0);

    // Reset two cycles into RUN, with EQ/LT previously non-zero.
    cmp8(8'h00, 8'h01, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h44; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst busy", int'(busy8), 0);
    chk("rst done", int'(done8), 0);
    chk("rst EQ", int'(eq8), 0);
    chk("rst LT", int'(lt8), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) seen++;
    end
    chk("rst no_done_after", seen, 0);
    cmp8(8'h5A, 8'h5A, 1'b1, 1'b0, "post_reset");

    cmp2(2'b01, 2'b10, 1'b0, 1'b1, "s2_lt");
    cmp2(2'b11, 2'b11, 1'b1, 1'b0, "s2_eq");
    cmp2(2'b10, 2'b01, 1'b0, 1'b0, "s2_gt");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
